// File: rtl/hazard_ctl.sv
// Pipeline hazard control: load-use and mul/div stalls, taken-branch flush,
// and the mul/div busy sequencer that drives HI/LO writeback.
module hazard_ctl #(
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] rs_2,
  input  logic [4:0] rt_2,
  input  logic       UseRt_2,
  input  logic       MdUse_2,
  input  logic       MemRead_3,
  input  logic [4:0] rt_3,
  input  logic       BrTaken_3,
  input  logic       MdStart_3,
  input  logic       MdOp_3,
  output logic       PCWr,
  output logic       IFIDWr,
  output logic       IFIDFlush,
  output logic       IDEXFlush,
  output logic       MdGo,
  output logic       MdBusy,
  output logic       HiLoWr,
  output logic       MdErr
);

  localparam logic       IDLE    = 1'b0;
  localparam logic       RUN     = 1'b1;
  localparam logic [5:0] MUL_CNT = 6'(MUL_LAT);
  localparam logic [5:0] DIV_CNT = 6'(DIV_LAT);

  logic       state, state_d;
  logic [5:0] cnt, cnt_d;
  logic       err_d;
  logic       lu, md, stall;

  // A start seen while already running is dropped; it only raises the error flag.
  always_comb begin
    MdGo    = (state == IDLE) & MdStart_3;
    MdBusy  = (state == RUN);
    HiLoWr  = MdBusy & (cnt == 6'd1);
    state_d = state;
    cnt_d   = cnt;
    err_d   = MdErr | (MdBusy & MdStart_3);
    if (MdGo) begin
      state_d = RUN;
      cnt_d   = MdOp_3 ? DIV_CNT : MUL_CNT;
    end else if (MdBusy) begin
      if (cnt == 6'd1) begin
        state_d = IDLE;
        cnt_d   = 6'd0;
      end else begin
        cnt_d = cnt - 6'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 6'd0;
      MdErr <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      MdErr <= err_d;
    end
  end

  // The MdGo term covers the start cycle itself, before RUN is visible.
  always_comb begin
    lu    = MemRead_3 & (rt_3 != 5'd0) &
            ((rt_3 == rs_2) | (UseRt_2 & (rt_3 == rt_2)));
    md    = MdUse_2 & (MdBusy | MdGo);
    stall = lu | md;
    PCWr      = 1'b1;
    IFIDWr    = 1'b1;
    IFIDFlush = 1'b0;
    IDEXFlush = 1'b0;
    if (BrTaken_3) begin
      IFIDFlush = 1'b1;
      IDEXFlush = 1'b1;
    end else if (stall) begin
      PCWr      = 1'b0;
      IFIDWr    = 1'b0;
      IDEXFlush = 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctl.sv
// Bench for hazard_ctl: directed literal checks plus randomized traffic
// compared every cycle against a remaining-busy-cycles model.
module tb_hazard_ctl;
  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] rs_2 = '0, rt_2 = '0, rt_3 = '0;
  logic UseRt_2 = 0, MdUse_2 = 0, MemRead_3 = 0, BrTaken_3 = 0, MdStart_3 = 0, MdOp_3 = 0;
  logic PCWr, IFIDWr, IFIDFlush, IDEXFlush, MdGo, MdBusy, HiLoWr, MdErr;

  int n_cmp = 0;
  int n_bad = 0;

  // model: cycles of mul/div work left (0 = idle) and sticky error
  int rem;
  bit err;

  always #5 clk = ~clk;

  hazard_ctl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .rs_2(rs_2), .rt_2(rt_2), .UseRt_2(UseRt_2),
    .MdUse_2(MdUse_2), .MemRead_3(MemRead_3), .rt_3(rt_3), .BrTaken_3(BrTaken_3),
    .MdStart_3(MdStart_3), .MdOp_3(MdOp_3), .PCWr(PCWr), .IFIDWr(IFIDWr),
    .IFIDFlush(IFIDFlush), .IDEXFlush(IDEXFlush), .MdGo(MdGo), .MdBusy(MdBusy),
    .HiLoWr(HiLoWr), .MdErr(MdErr)
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem <= 0;
      err <= 1'b0;
    end else if (rem > 0) begin
      if (MdStart_3) err <= 1'b1;
      rem <= rem - 1;
    end else if (MdStart_3) begin
      rem <= MdOp_3 ? DIV_LAT : MUL_LAT;
    end
  end

  always @(negedge clk) begin
    bit busy, go, lu, md;
    logic [7:0] exp_v, act_v;
    busy = (rem > 0);
    go   = !busy && MdStart_3;
    lu   = MemRead_3 && (rt_3 != 0) && ((rt_3 == rs_2) || (UseRt_2 && (rt_3 == rt_2)));
    md   = MdUse_2 && (busy || go);
    if (BrTaken_3)     exp_v[7:4] = 4'b1111;
    else if (lu || md) exp_v[7:4] = 4'b0001;
    else               exp_v[7:4] = 4'b1100;
    exp_v[3:0] = {go, busy, rem == 1, err};
    act_v = {PCWr, IFIDWr, IFIDFlush, IDEXFlush, MdGo, MdBusy, HiLoWr, MdErr};
    n_cmp++;
    if (act_v !== exp_v) begin
      n_bad++;
      $display("FAIL cycle_check t=%0t got %b expected %b {PCWr,IFIDWr,IFIDFlush,IDEXFlush,MdGo,MdBusy,HiLoWr,MdErr}",
               $time, act_v, exp_v);
    end
  end

  task automatic lit(input string nm, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s t=%0t got %0d expected %0d", nm, $time, act, exp_v);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    // reset state
    #2;
    lit("reset_outputs", {PCWr, IFIDWr, IFIDFlush, IDEXFlush, MdGo, MdBusy, HiLoWr, MdErr}, 8'b1100_0000);
    cyc(); cyc();
    rst_n = 1'b1;

    // load-use hazard and its r0 exemption
    cyc(); MemRead_3 = 1; rt_3 = 8; rs_2 = 8; #1;
    lit("lu_stall", {PCWr, IFIDWr, IDEXFlush}, 3'b001);
    cyc(); MemRead_3 = 0; #1;
    lit("lu_release", {PCWr, IFIDWr, IDEXFlush}, 3'b110);
    cyc(); MemRead_3 = 1; rt_3 = 0; rs_2 = 0; #1;
    lit("lu_r0", {PCWr, IFIDWr, IDEXFlush}, 3'b110);
    cyc(); MemRead_3 = 1; rt_3 = 9; rs_2 = 3; rt_2 = 9; UseRt_2 = 1; #1;
    lit("lu_rt", {PCWr, IFIDWr, IDEXFlush}, 3'b001);
    cyc(); MemRead_3 = 0; UseRt_2 = 0; rt_3 = 0; rs_2 = 0; rt_2 = 0; #1;

    // multiply: go, then five busy cycles with HiLoWr on the last
    cyc(); MdStart_3 = 1; MdOp_3 = 0; #1;
    lit("mul_go", {MdGo, MdBusy}, 2'b10);
    for (int i = 1; i <= 5; i++) begin
      cyc(); MdStart_3 = 0; #1;
      lit("mul_busy", {MdGo, MdBusy, HiLoWr}, (i == 5) ? 3'b011 : 3'b010);
    end
    cyc(); #1;
    lit("mul_idle", {MdBusy, HiLoWr}, 2'b00);

    // dependent mflo held from a divide start
    cyc(); MdStart_3 = 1; MdOp_3 = 1; MdUse_2 = 1; #1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (PCWr) break;
      n++;
      cyc(); MdStart_3 = 0; #1;
    end
    lit("div_stall_len", n, 33);
    MdUse_2 = 0;

    // taken branch during an MDU stall
    cyc(); MdStart_3 = 1; MdOp_3 = 0; MdUse_2 = 1; #1;
    cyc(); MdStart_3 = 0; BrTaken_3 = 1; #1;
    lit("br_flush", {PCWr, IFIDWr, IFIDFlush, IDEXFlush, MdBusy}, 5'b11111);
    cyc(); BrTaken_3 = 0; #1;
    lit("br_then_stall", {PCWr, IDEXFlush, HiLoWr}, 3'b010);
    cyc(); cyc(); #1;
    lit("br_no_hilo_yet", HiLoWr, 0);
    cyc(); #1;
    lit("br_hilo_on_time", HiLoWr, 1);
    MdUse_2 = 0;
    cyc(); #1;

    // protocol error at cnt=10 of a divide
    cyc(); MdStart_3 = 1; MdOp_3 = 1; #1;
    for (int k = 1; k <= 23; k++) begin
      cyc(); MdStart_3 = 0; #1;
    end
    MdStart_3 = 1; MdOp_3 = 0; #1;
    lit("err_not_yet", {MdErr, MdGo}, 2'b00);
    cyc(); MdStart_3 = 0; #1;
    lit("err_set", {MdErr, MdBusy, HiLoWr}, 3'b110);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(); #1;
      n++;
      if (HiLoWr) break;
    end
    lit("err_cnt_continues", n, 8);
    cyc(); #1;
    lit("err_sticky", {MdErr, MdBusy}, 2'b10);

    // reset mid-run aborts the operation
    cyc(); MdStart_3 = 1; MdOp_3 = 0; #1;
    cyc(); cyc(); MdStart_3 = 0; #1;
    rst_n = 0; #1;
    lit("rst_mid_run", {MdBusy, MdErr, HiLoWr}, 3'b000);
    cyc(); rst_n = 1; #1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(); #1;
      if (HiLoWr || MdBusy) n++;
    end
    lit("rst_no_hilo", n, 0);

    // randomized traffic, checked every cycle by the model
    for (int i = 0; i < 4000; i++) begin
      cyc();
      rs_2      = 5'($urandom_range(0, 3));
      rt_2      = 5'($urandom_range(0, 3));
      rt_3      = 5'($urandom_range(0, 3));
      UseRt_2   = 1'($urandom_range(0, 1));
      MdUse_2   = ($urandom_range(0, 3) == 0);
      MemRead_3 = ($urandom_range(0, 2) == 0);
      BrTaken_3 = ($urandom_range(0, 7) == 0);
      MdStart_3 = ($urandom_range(0, 9) == 0);
      MdOp_3    = ($urandom_range(0, 3) == 0);
      rst_n     = ($urandom_range(0, 299) != 0);
    end
    cyc();
    rst_n = 1; MdStart_3 = 0;
    cyc(); cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/hazard_ctl.md
HAZARD_CTL -- requirements
Module: hazard_ctl

Interface
REQ-001 Parameter MUL_LAT, default 5, sets the number of busy cycles for a mult/multu operation (legal range 1..63).
REQ-002 Parameter DIV_LAT, default 32, sets the number of busy cycles for a div/divu operation (legal range 1..63).
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port rs_2, input, 5 bits: rs field of the instruction in ID.
REQ-006 Port rt_2, input, 5 bits: rt field of the instruction in ID.
REQ-007 Port UseRt_2, input, 1 bit: the ID instruction reads rt as a source.
REQ-008 Port MdUse_2, input, 1 bit: the ID instruction is mfhi/mflo/mthi/mtlo or mult/div.
REQ-009 Port MemRead_3, input, 1 bit: the EX instruction is a load.
REQ-010 Port rt_3, input, 5 bits: load destination register in EX.
REQ-011 Port BrTaken_3, input, 1 bit: a branch/jump resolved taken in EX.
REQ-012 Port MdStart_3, input, 1 bit: the EX instruction is mult/multu/div/divu.
REQ-013 Port MdOp_3, input, 1 bit: 0 = multiply, 1 = divide.
REQ-014 Port PCWr, output, 1 bit: PC write enable.
REQ-015 Port IFIDWr, output, 1 bit: IF/ID register write enable.
REQ-016 Port IFIDFlush, output, 1 bit: clears IF/ID to a nop.
REQ-017 Port IDEXFlush, output, 1 bit: loads a bubble into ID/EX.
REQ-018 Port MdGo, output, 1 bit: single-cycle start strobe to the mul/div unit.
REQ-019 Port MdBusy, output, 1 bit: the mul/div unit is running.
REQ-020 Port HiLoWr, output, 1 bit: HI/LO write strobe on the last busy cycle.
REQ-021 Port MdErr, output, 1 bit: sticky protocol-error flag.

Function
REQ-022 Two states, IDLE and RUN, plus a 6-bit down-counter cnt.
REQ-023 IDLE with MdStart_3=1: MdGo=1 in that cycle; next state RUN; cnt loads MUL_LAT when MdOp_3=0, DIV_LAT when MdOp_3=1.
REQ-024 RUN: MdBusy=1; cnt decrements by 1 each cycle; when cnt==1, HiLoWr=1 and the next state is IDLE with cnt=0.
REQ-025 RUN therefore lasts exactly MUL_LAT or DIV_LAT cycles; HiLoWr is high for exactly one cycle per operation.
REQ-026 RUN with MdStart_3=1 is a protocol error: the start is ignored, cnt is not reloaded, and MdErr is set and held until reset.
REQ-027 Load-use hazard lu = MemRead_3 & (rt_3!=0) & ((rt_3==rs_2) | (UseRt_2 & (rt_3==rt_2))); combinational.
REQ-028 MDU hazard md = MdUse_2 & (state==RUN | MdGo); combinational.
REQ-029 Stall (lu|md, no taken branch): PCWr=0, IFIDWr=0, IDEXFlush=1, IFIDFlush=0.
REQ-030 BrTaken_3=1 has highest priority: PCWr=1, IFIDWr=1, IFIDFlush=1, IDEXFlush=1, regardless of lu/md.
REQ-031 A taken branch does not affect the mul/div FSM, cnt, or HiLoWr.
REQ-032 No hazard and no branch: PCWr=1, IFIDWr=1, IFIDFlush=0, IDEXFlush=0.
REQ-033 The load-use stall lasts one cycle; a multi-cycle stall arises only from md and releases in the cycle after HiLoWr.

Reset
REQ-034 rst_n=0 asynchronously forces state=IDLE, cnt=0, MdErr=0, including mid-RUN (no HiLoWr is issued for the aborted operation).
REQ-035 While rst_n=0 with all inputs at 0: PCWr=1, IFIDWr=1, IFIDFlush=0, IDEXFlush=0, MdGo=0, MdBusy=0, HiLoWr=0, MdErr=0.

Verification
REQ-036 Load-use stall: MemRead_3=1, rt_3=8, rs_2=8 -> one cycle of PCWr=0, IFIDWr=0, IDEXFlush=1. With rt_3=0 instead -> no stall.
REQ-037 Multiply: MdStart_3=1, MdOp_3=0 in IDLE -> MdGo for 1 cycle, then MdBusy for 5 cycles, HiLoWr on the 5th, IDLE on the 6th.
REQ-038 Dependent mflo: MdUse_2=1 held from the start cycle of a divide -> stalled for 33 cycles (the start cycle plus 32 RUN cycles); released in the cycle after HiLoWr.
REQ-039 Branch during MDU stall: BrTaken_3=1 in RUN with MdUse_2=1 -> IFIDFlush=1, IDEXFlush=1, PCWr=1; cnt continues decrementing unchanged.
REQ-040 Protocol error and reset: MdStart_3=1 in RUN with cnt=10 -> cnt continues 9, 8, ... and MdErr=1; rst_n pulsed low mid-RUN -> immediate IDLE, MdBusy=0, MdErr=0, no HiLoWr.
